mp_coherence_bus: RTL and testbench

- N-core successor to the two-core coherence bus.
- Arbitrates RAM among N instruction caches and N data caches, and runs snoop/invalidate broadcasts to all non-requesting caches.
- Supports cache-to-cache block transfer with concurrent RAM writeback.
- Block size is parametrised in words. Sits between the per-core caches and the single RAM port.

---
 rtl/mp_coherence_bus_pkg.sv | 26 ++
 rtl/mp_coherence_bus_rr_arbiter.sv | 27 ++
 rtl/mp_coherence_bus.sv | 200 ++++++++++++++++++++
 tb/tb_mp_coherence_bus.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_coherence_bus_pkg.sv
// Shared types for the multi-core coherence bus: RAM handshake states and bus FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WB         = 3'd1,
        IFETCH     = 3'd2,
        SNOOP_REQ  = 3'd3,
        SNOOP_RESP = 3'd4,
        FILL       = 3'd5,
        C2C        = 3'd6
    } bus_state_t;

    // Beat counter must be able to hold BLOCK_WORDS itself.
    function automatic int beat_width(input int block_words);
        return $clog2(block_words + 1);
    endfunction

endpackage

// File: rtl/mp_coherence_bus_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        int w_cand;
        w_cand  = 0;
        o_valid = 1'b0;
        o_idx   = '0;
        // Scan farthest offset first so the nearest request overwrites.
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = (int'(i_ptr) + k) % N;
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = IW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/mp_coherence_bus.sv
// N-core coherence bus: arbitrates the RAM port among I/D caches, runs snoops,
// and supports cache-to-cache block transfer with concurrent RAM writeback.
module mp_coherence_bus
    import cpu_types_pkg::*;
#(
    parameter int NCPUS       = 4,
    parameter int BLOCK_WORDS = 2,
    parameter int WORD_W      = 32
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NCPUS-1:0]              iREN,
    input  logic [NCPUS-1:0]              dREN,
    input  logic [NCPUS-1:0]              dWEN,
    input  logic [NCPUS-1:0][WORD_W-1:0]  iaddr,
    input  logic [NCPUS-1:0][WORD_W-1:0]  daddr,
    input  logic [NCPUS-1:0][WORD_W-1:0]  dstore,
    input  logic [NCPUS-1:0]              ccwrite,
    input  logic [NCPUS-1:0]              cctrans,
    output logic [NCPUS-1:0]              iwait,
    output logic [NCPUS-1:0]              dwait,
    output logic [NCPUS-1:0][WORD_W-1:0]  iload,
    output logic [NCPUS-1:0][WORD_W-1:0]  dload,
    output logic [NCPUS-1:0]              ccwait,
    output logic [NCPUS-1:0]              ccinv,
    output logic [NCPUS-1:0][WORD_W-1:0]  ccsnoopaddr,
    input  ramstate_t                     ramstate,
    input  logic [WORD_W-1:0]             ramload,
    output logic                          ramREN,
    output logic                          ramWEN,
    output logic [WORD_W-1:0]             ramaddr,
    output logic [WORD_W-1:0]             ramstore
);

    localparam int IDX_W  = $clog2(NCPUS);
    localparam int BEAT_W = beat_width(BLOCK_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

    bus_state_t         r_fsm, w_fsm_next;
    logic [IDX_W-1:0]   r_req, w_req_next;
    logic [IDX_W-1:0]   r_resp, w_resp_next;
    logic [BEAT_W-1:0]  r_beat, w_beat_next;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_next;

    logic               w_wb_valid, w_rd_valid, w_if_valid;
    logic [IDX_W-1:0]   w_wb_idx, w_rd_idx, w_if_idx;
    logic [NCPUS-1:0]   w_others;
    logic [NCPUS-1:0]   w_trans;
    logic [IDX_W-1:0]   w_trans_idx;
    logic [IDX_W-1:0]   w_ptr_after;
    logic               w_access;
    logic               w_last;

    rr_arbiter #(.N(NCPUS)) u_arb_wb (.i_req(dWEN), .i_ptr(r_rr_ptr), .o_valid(w_wb_valid), .o_idx(w_wb_idx));
    rr_arbiter #(.N(NCPUS)) u_arb_rd (.i_req(dREN), .i_ptr(r_rr_ptr), .o_valid(w_rd_valid), .o_idx(w_rd_idx));
    rr_arbiter #(.N(NCPUS)) u_arb_if (.i_req(iREN), .i_ptr(r_rr_ptr), .o_valid(w_if_valid), .o_idx(w_if_idx));

    assign w_access    = (ramstate == ACCESS);
    assign w_last      = (r_beat == LAST_BEAT);
    assign w_ptr_after = (r_req == IDX_W'(NCPUS - 1)) ? '0 : r_req + 1'b1;
    assign w_trans     = cctrans & w_others;

    always_comb begin
        w_others        = '1;
        w_others[r_req] = 1'b0;
    end

    // Lowest-numbered Modified holder supplies the block.
    always_comb begin
        w_trans_idx = '0;
        for (int j = NCPUS - 1; j >= 0; j--) begin
            if (w_trans[j]) w_trans_idx = IDX_W'(j);
        end
    end

    always_comb begin
        w_fsm_next    = r_fsm;
        w_req_next    = r_req;
        w_resp_next   = r_resp;
        w_beat_next   = r_beat;
        w_rr_ptr_next = r_rr_ptr;
        case (r_fsm)
            IDLE: begin
                w_beat_next = '0;
                if (w_wb_valid) begin
                    w_req_next = w_wb_idx;
                    w_fsm_next = WB;
                end else if (w_rd_valid) begin
                    w_req_next = w_rd_idx;
                    w_fsm_next = SNOOP_REQ;
                end else if (w_if_valid) begin
                    w_req_next = w_if_idx;
                    w_fsm_next = IFETCH;
                end
            end
            IFETCH: begin
                if (w_access) begin
                    w_fsm_next    = IDLE;
                    w_rr_ptr_next = w_ptr_after;
                end
            end
            SNOOP_REQ: w_fsm_next = SNOOP_RESP;
            SNOOP_RESP: begin
                if (|w_trans) begin
                    w_resp_next = w_trans_idx;
                    w_fsm_next  = C2C;
                end else begin
                    w_fsm_next  = FILL;
                end
            end
            WB, FILL, C2C: begin
                if (w_access) begin
                    w_beat_next = r_beat + 1'b1;
                    if (w_last) begin
                        w_fsm_next    = IDLE;
                        w_rr_ptr_next = w_ptr_after;
                    end
                end
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_fsm    <= IDLE;
            r_req    <= '0;
            r_resp   <= '0;
            r_beat   <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_fsm    <= w_fsm_next;
            r_req    <= w_req_next;
            r_resp   <= w_resp_next;
            r_beat   <= w_beat_next;
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (r_fsm)
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[r_req];
                ramstore = dstore[r_req];
                if (w_access) dwait[r_req] = 1'b0;
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[r_req];
                if (w_access) begin
                    iwait[r_req] = 1'b0;
                    iload[r_req] = ramload;
                end
            end
            SNOOP_REQ, SNOOP_RESP: begin
                ccwait = w_others;
                for (int j = 0; j < NCPUS; j++) begin
                    if (w_others[j]) ccsnoopaddr[j] = daddr[r_req];
                end
                if (r_fsm == SNOOP_RESP && ccwrite[r_req]) ccinv = w_others;
            end
            FILL: begin
                ccwait  = w_others;
                ramREN  = 1'b1;
                ramaddr = daddr[r_req];
                if (w_access) begin
                    dload[r_req] = ramload;
                    dwait[r_req] = 1'b0;
                end
            end
            C2C: begin
                // Supplier data goes to the requester and to RAM in the same beat.
                ccwait              = w_others;
                ccsnoopaddr[r_resp] = daddr[r_req];
                dload[r_req]        = dstore[r_resp];
                ramWEN              = 1'b1;
                ramaddr             = daddr[r_req];
                ramstore            = dstore[r_resp];
                if (w_access) begin
                    dwait[r_req]  = 1'b0;
                    dwait[r_resp] = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mp_coherence_bus.sv
// Self-checking bench for mp_coherence_bus: transaction-level model plus directed scenarios.
module tb_mp_coherence_bus;
    import cpu_types_pkg::*;

    localparam int N  = 4;
    localparam int BW = 2;
    localparam int W  = 32;
    localparam logic [W-1:0] K = 32'hA5A50000;

    logic CLK = 1'b0;
    logic nRST;
    logic [N-1:0] iREN, dREN, dWEN, ccwrite, cctrans;
    logic [N-1:0][W-1:0] iaddr, daddr, dstore;
    logic [N-1:0] iwait, dwait, ccwait, ccinv;
    logic [N-1:0][W-1:0] iload, dload, ccsnoopaddr;
    ramstate_t ramstate;
    logic [W-1:0] ramload, ramaddr, ramstore;
    logic ramREN, ramWEN;

    mp_coherence_bus #(.NCPUS(N), .BLOCK_WORDS(BW), .WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite), .cctrans(cctrans),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ccwait(ccwait),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramstate(ramstate), .ramload(ramload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    // Cache and RAM stand-ins
    int base_d [N];
    int beats_d [N];
    logic [W-1:0] sup_data [N][BW];
    int ram_cnt;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            daddr[k]  = W'(base_d[k] + 4 * beats_d[k]);
            dstore[k] = sup_data[k][beats_d[k] % BW];
        end
    end
    always_comb ramload = ramaddr ^ K;
    always_comb begin
        if (ramREN || ramWEN) ramstate = (ram_cnt >= 2) ? ACCESS : BUSY;
        else                  ramstate = FREE;
    end

    // Transaction-level reference: kind 0 none, 1 writeback, 2 ifetch, 3 read-miss
    typedef struct {
        int kind; int req; int sup; int stage; int done; int ptr;
    } model_t;
    typedef struct packed {
        logic [N-1:0] iw, dw, cw, ci;
        logic [N-1:0][W-1:0] il, dl, sa;
        logic rr, rw;
        logic [W-1:0] ra, rs;
    } outs_t;

    model_t m;
    logic [N-1:0] s_iren, s_dren, s_dwen, s_cctrans;
    logic s_acc;

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic model_t model_next(input model_t c);
        model_t n;
        n = c;
        if (c.kind == 0) begin
            n.done = 0; n.stage = 0; n.sup = -1;
            if (pick(s_dwen, c.ptr) >= 0)      begin n.kind = 1; n.req = pick(s_dwen, c.ptr); end
            else if (pick(s_dren, c.ptr) >= 0) begin n.kind = 3; n.req = pick(s_dren, c.ptr); end
            else if (pick(s_iren, c.ptr) >= 0) begin n.kind = 2; n.req = pick(s_iren, c.ptr); end
        end else if (c.kind == 3 && c.stage < 2) begin
            if (c.stage == 1)
                for (int j = N - 1; j >= 0; j--) if (j != c.req && s_cctrans[j]) n.sup = j;
            n.stage = c.stage + 1;
        end else if (s_acc) begin
            n.done = c.done + 1;
            if (c.kind == 2 || n.done == BW) begin
                n.kind = 0;
                n.ptr = (c.req + 1) % N;
            end
        end
        return n;
    endfunction

    function automatic outs_t model_out(input model_t c);
        outs_t e;
        logic acc;
        acc = (ramstate == ACCESS);
        e = '0;
        e.iw = '1;
        e.dw = '1;
        if (c.kind == 1) begin
            e.rw = 1'b1; e.ra = daddr[c.req]; e.rs = dstore[c.req];
            if (acc) e.dw[c.req] = 1'b0;
        end else if (c.kind == 2) begin
            e.rr = 1'b1; e.ra = iaddr[c.req];
            if (acc) begin e.iw[c.req] = 1'b0; e.il[c.req] = iaddr[c.req] ^ K; end
        end else if (c.kind == 3) begin
            for (int j = 0; j < N; j++) if (j != c.req) e.cw[j] = 1'b1;
            if (c.stage < 2) begin
                for (int j = 0; j < N; j++) if (j != c.req) begin
                    e.sa[j] = daddr[c.req];
                    if (c.stage == 1) e.ci[j] = ccwrite[c.req];
                end
            end else if (c.sup < 0) begin
                e.rr = 1'b1; e.ra = daddr[c.req];
                if (acc) begin e.dl[c.req] = daddr[c.req] ^ K; e.dw[c.req] = 1'b0; end
            end else begin
                e.sa[c.sup] = daddr[c.req];
                e.dl[c.req] = dstore[c.sup];
                e.rw = 1'b1; e.ra = daddr[c.req]; e.rs = dstore[c.sup];
                if (acc) begin e.dw[c.req] = 1'b0; e.dw[c.sup] = 1'b0; end
            end
        end
        return e;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) m <= '{kind: 0, req: 0, sup: -1, stage: 0, done: 0, ptr: 0};
        else       m <= model_next(m);
    end

    // Event logs and per-cycle comparison
    int ev_q[$];
    logic [W-1:0] iload_q[$], dload0_q[$], wr_addr_q[$], wr_data_q[$];
    int rd_acc_cnt = 0, inv_cyc = 0, inv_any = 0, wait_cyc = 0, co_cnt = 0;
    logic [N-1:0] fl_dw, fl_iw;
    logic fl_act, fl_acc;

    always @(negedge CLK) begin
        outs_t e;
        e = model_out(m);
        chk("iwait", iwait, e.iw);
        chk("dwait", dwait, e.dw);
        chk("ccwait", ccwait, e.cw);
        chk("ccinv", ccinv, e.ci);
        chk("iload", iload, e.il);
        chk("dload", dload, e.dl);
        chk("ccsnoopaddr", ccsnoopaddr, e.sa);
        chk("ramREN", ramREN, e.rr);
        chk("ramWEN", ramWEN, e.rw);
        chk("ramaddr", ramaddr, e.ra);
        chk("ramstore", ramstore, e.rs);
        for (int k = 0; k < N; k++) begin
            if (!dwait[k]) ev_q.push_back(10 + k);
            if (!iwait[k]) begin ev_q.push_back(20 + k); iload_q.push_back(iload[k]); end
        end
        if (!dwait[0]) dload0_q.push_back(dload[0]);
        if (ramWEN && ramstate == ACCESS) begin wr_addr_q.push_back(ramaddr); wr_data_q.push_back(ramstore); end
        if (ramREN && ramstate == ACCESS) rd_acc_cnt <= rd_acc_cnt + 1;
        if (ccinv == 4'b1110) inv_cyc <= inv_cyc + 1;
        if (ccinv != 4'b0000) inv_any <= inv_any + 1;
        if (ccwait == 4'b1110) wait_cyc <= wait_cyc + 1;
        if (!dwait[0] && !dwait[3]) co_cnt <= co_cnt + 1;
        s_iren <= iREN; s_dren <= dREN; s_dwen <= dWEN; s_cctrans <= cctrans;
        s_acc <= (ramstate == ACCESS);
        fl_dw <= ~dwait; fl_iw <= ~iwait;
        fl_act <= ramREN | ramWEN; fl_acc <= (ramstate == ACCESS);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (nRST) begin
            for (int k = 0; k < N; k++) begin
                if (fl_dw[k]) begin
                    beats_d[k]++;
                    if (beats_d[k] >= BW) begin dWEN[k] = 1'b0; dREN[k] = 1'b0; end
                end
                if (fl_iw[k]) iREN[k] = 1'b0;
            end
            ram_cnt = (fl_act && !fl_acc) ? ram_cnt + 1 : 0;
        end else begin
            ram_cnt = 0;
        end
    endtask

    task automatic wait_done(input string nm);
        int cyc;
        cyc = 0;
        while ((iREN | dREN | dWEN) != '0 && cyc < 200) begin tick(); cyc++; end
        checks++;
        if ((iREN | dREN | dWEN) != '0) begin
            failures++;
            $display("FAIL %s timeout pending=%b required=0", nm, iREN | dREN | dWEN);
        end
        tick(); tick();
    endtask

    int s_ev, s_il, s_dl, s_wr, s_rd, s_inv, s_invany, s_wait, s_co;

    task automatic mark();
        s_ev = ev_q.size(); s_il = iload_q.size(); s_dl = dload0_q.size();
        s_wr = wr_addr_q.size(); s_rd = rd_acc_cnt; s_inv = inv_cyc;
        s_invany = inv_any; s_wait = wait_cyc; s_co = co_cnt;
    endtask

    initial begin
        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        ram_cnt = 0;
        for (int k = 0; k < N; k++) begin
            iaddr[k] = W'(32'h200 + 16 * k);
            base_d[k] = 0; beats_d[k] = 0;
            for (int b = 0; b < BW; b++) sup_data[k][b] = W'(32'h1000 * (k + 1) + b);
        end
        #12;
        chk("rst_iwait", iwait, 4'hF);
        chk("rst_dwait", dwait, 4'hF);
        chk("rst_ramREN", ramREN, 1'b0);
        chk("rst_ccwait", ccwait, 4'h0);
        #10 nRST = 1'b1;
        tick();

        // Writeback from core 2
        mark();
        base_d[2] = 32'h100; beats_d[2] = 0;
        sup_data[2][0] = 32'h11112222; sup_data[2][1] = 32'h33334444;
        dWEN[2] = 1'b1;
        wait_done("wb2");
        chk("wb_count", wr_addr_q.size() - s_wr, 2);
        chk("wb_addr0", wr_addr_q[s_wr], 32'h100);
        chk("wb_addr1", wr_addr_q[s_wr + 1], 32'h104);
        chk("wb_data1", wr_data_q[s_wr + 1], 32'h33334444);
        chk("wb_dwait_lows", ev_q.size() - s_ev, 2);
        chk("wb_rr_ptr", dut.r_rr_ptr, 2'd3);

        // Writeback core 1 beats ifetch core 0 in the same cycle
        mark();
        base_d[1] = 32'h300; beats_d[1] = 0;
        dWEN[1] = 1'b1; iREN[0] = 1'b1;
        wait_done("wb_vs_if");
        chk("prio_n", ev_q.size() - s_ev, 3);
        chk("prio_ev0", ev_q[s_ev], 11);
        chk("prio_ev1", ev_q[s_ev + 1], 11);
        chk("prio_ev2", ev_q[s_ev + 2], 20);
        chk("prio_rr_ptr", dut.r_rr_ptr, 2'd1);

        // Three ifetches with rr_ptr=1
        mark();
        iREN = 4'b1011;
        wait_done("if3");
        chk("rr_n", ev_q.size() - s_ev, 3);
        chk("rr_g0", ev_q[s_ev], 21);
        chk("rr_g1", ev_q[s_ev + 1], 23);
        chk("rr_g2", ev_q[s_ev + 2], 20);
        chk("rr_load0", iload_q[s_il], 32'hA5A50210);
        chk("rr_load1", iload_q[s_il + 1], 32'hA5A50230);
        chk("rr_load2", iload_q[s_il + 2], 32'hA5A50200);

        // Read-exclusive miss, no supplier: RAM fill
        mark();
        base_d[0] = 32'h400; beats_d[0] = 0;
        ccwrite[0] = 1'b1; dREN[0] = 1'b1;
        wait_done("fill");
        ccwrite[0] = 1'b0;
        chk("fill_inv_cycles", inv_cyc - s_inv, 1);
        chk("fill_inv_any", inv_any - s_invany, 1);
        chk("fill_wait_cycles", wait_cyc - s_wait, 8);
        chk("fill_reads", rd_acc_cnt - s_rd, 2);
        chk("fill_d0", dload0_q[s_dl], 32'hA5A50400);
        chk("fill_d1", dload0_q[s_dl + 1], 32'hA5A50404);

        // Read miss supplied by core 3 (Modified)
        mark();
        base_d[0] = 32'h500; beats_d[0] = 0; beats_d[3] = 0;
        sup_data[3][0] = 32'hDEADBEEF; sup_data[3][1] = 32'hCAFEF00D;
        cctrans[3] = 1'b1; dREN[0] = 1'b1;
        wait_done("c2c");
        cctrans[3] = 1'b0;
        chk("c2c_d0", dload0_q[s_dl], 32'hDEADBEEF);
        chk("c2c_d1", dload0_q[s_dl + 1], 32'hCAFEF00D);
        chk("c2c_wa0", wr_addr_q[s_wr], 32'h500);
        chk("c2c_wa1", wr_addr_q[s_wr + 1], 32'h504);
        chk("c2c_wd1", wr_data_q[s_wr + 1], 32'hCAFEF00D);
        chk("c2c_colow", co_cnt - s_co, 2);
        chk("c2c_noinv", inv_any - s_invany, 0);

        // Reset during beat 1 of a fill
        mark();
        base_d[0] = 32'h600; beats_d[0] = 0;
        dREN[0] = 1'b1;
        begin
            int cyc;
            cyc = 0;
            while (beats_d[0] < 1 && cyc < 100) begin tick(); cyc++; end
            checks++;
            if (beats_d[0] < 1) begin
                failures++;
                $display("FAIL rst_fill timeout beats=%0d required=1", beats_d[0]);
            end
        end
        tick();
        #3 nRST = 1'b0;
        #1;
        chk("midrst_iwait", iwait, 4'hF);
        chk("midrst_dwait", dwait, 4'hF);
        chk("midrst_ccwait", ccwait, 4'h0);
        chk("midrst_ramREN", ramREN, 1'b0);
        chk("midrst_ramaddr", ramaddr, 32'h0);
        chk("midrst_rr_ptr", dut.r_rr_ptr, 2'd0);
        chk("midrst_fsm", dut.r_fsm, IDLE);
        beats_d[0] = 0;
        tick(); tick();
        nRST = 1'b1;
        mark();
        tick();
        chk("rearb_ccwait", ccwait, 4'b1110);
        chk("rearb_ramREN", ramREN, 1'b0);
        wait_done("rearb");
        chk("rearb_d0", dload0_q[s_dl], 32'hA5A50600);
        chk("rearb_d1", dload0_q[s_dl + 1], 32'hA5A50604);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
